// File: rtl/vector_aggregator_if.sv
// Handshake and data bundle between the vectorization unit, vector_aggregator and the next stage.
// The master modport is the driving environment; the slave modport is the aggregator.
interface vector_aggregator_if #(
    parameter int FEATURES   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 4
);
    logic                           start;
    logic [CNT_W-1:0]               num_neigh;
    logic                           vld_in;
    logic [FEATURES*DATA_WIDTH-1:0] din;
    logic                           ready_out;
    logic                           vld_out;
    logic [FEATURES*DATA_WIDTH-1:0] dout;
    logic                           rdy_in;
    logic                           busy;
    logic                           drop_err;

    modport master (
        output start, num_neigh, vld_in, din, rdy_in,
        input  ready_out, vld_out, dout, busy, drop_err
    );

    modport slave (
        input  start, num_neigh, vld_in, din, rdy_in,
        output ready_out, vld_out, dout, busy, drop_err
    );
endinterface

// File: rtl/vector_aggregator.sv
// Lane-wise sum of a programmed number of feature vectors, presented through a valid/ready output.
// Define AGG_SATURATE_EN to saturate each output lane instead of truncating it.
module vector_aggregator #(
    parameter int FEATURES   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 4
) (
    input logic              clk,
    input logic              arst,
    vector_aggregator_if.slave agg
);
    localparam int ACC_WIDTH = DATA_WIDTH + CNT_W;
    localparam int VEC_W     = FEATURES * DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUTPUT} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     remaining_q, remaining_d;
    logic                 drop_err_q, drop_err_d;
    logic [VEC_W-1:0]     dout_q, dout_d;
    logic [VEC_W-1:0]     narrow;
    logic                 clear_acc;
    logic                 accept;
    logic [ACC_WIDTH-1:0] acc_q [FEATURES];
    logic [ACC_WIDTH-1:0] acc_d [FEATURES];

    assign clear_acc = (state_q == S_IDLE) && agg.start;
    assign accept    = (state_q == S_ACCUM) && agg.vld_in;

    generate
        for (genvar gi = 0; gi < FEATURES; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] lane_in;
            assign lane_in = agg.din[gi*DATA_WIDTH +: DATA_WIDTH];

            always_comb begin
                acc_d[gi] = acc_q[gi];
                if (clear_acc) begin
                    acc_d[gi] = '0;
                end else if (accept) begin
                    acc_d[gi] = acc_q[gi] + {{CNT_W{lane_in[DATA_WIDTH-1]}}, lane_in};
                end
            end

            always_ff @(posedge clk or posedge arst) begin
                if (arst) begin
                    acc_q[gi] <= '0;
                end else begin
                    acc_q[gi] <= acc_d[gi];
                end
            end

`ifdef AGG_SATURATE_EN
            // In range exactly when the bits above the output sign bit all match it.
            logic [CNT_W:0] upper;
            assign upper = acc_d[gi][ACC_WIDTH-1:DATA_WIDTH-1];
            always_comb begin
                if ((upper == '0) || (upper == '1)) begin
                    narrow[gi*DATA_WIDTH +: DATA_WIDTH] = acc_d[gi][DATA_WIDTH-1:0];
                end else if (acc_d[gi][ACC_WIDTH-1]) begin
                    narrow[gi*DATA_WIDTH +: DATA_WIDTH] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
                end else begin
                    narrow[gi*DATA_WIDTH +: DATA_WIDTH] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
                end
            end
`else
            assign narrow[gi*DATA_WIDTH +: DATA_WIDTH] = acc_d[gi][DATA_WIDTH-1:0];
`endif
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        drop_err_d  = drop_err_q;
        dout_d      = dout_q;
        case (state_q)
            S_IDLE: begin
                if (agg.start) begin
                    drop_err_d = 1'b0;
                    if (agg.num_neigh != '0) begin
                        remaining_d = agg.num_neigh;
                        state_d     = S_ACCUM;
                    end else begin
                        dout_d  = '0;
                        state_d = S_OUTPUT;
                    end
                end
                // A vector in the start cycle is dropped too, and its flag wins over the clear.
                if (agg.vld_in) begin
                    drop_err_d = 1'b1;
                end
            end
            S_ACCUM: begin
                if (agg.vld_in) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        dout_d  = narrow;
                        state_d = S_OUTPUT;
                    end
                end
            end
            S_OUTPUT: begin
                if (agg.vld_in) begin
                    drop_err_d = 1'b1;
                end
                if (agg.rdy_in) begin
                    dout_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                dout_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            drop_err_q  <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            drop_err_q  <= drop_err_d;
            dout_q      <= dout_d;
        end
    end

    assign agg.ready_out = (state_q == S_ACCUM);
    assign agg.vld_out   = (state_q == S_OUTPUT);
    assign agg.busy      = (state_q != S_IDLE);
    assign agg.drop_err  = drop_err_q;
    assign agg.dout      = dout_q;
endmodule

// File: tb/tb_vector_aggregator.sv
// Directed, table-driven bench for vector_aggregator (default 4 lanes x 8 bits).
// Expected sums are hand-computed; a few lanes differ when AGG_SATURATE_EN is defined.
module tb_vector_aggregator;
    localparam int FW = 32;

    logic clk = 1'b0;
    logic arst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vector_aggregator_if #(.FEATURES(4), .DATA_WIDTH(8), .CNT_W(4)) bus ();

    vector_aggregator #(.FEATURES(4), .DATA_WIDTH(8), .CNT_W(4)) dut (
        .clk  (clk),
        .arst (arst),
        .agg  (bus)
    );

    typedef struct {
        string               name;
        int                  n;
        logic [2:0][FW-1:0]  v;
        logic [FW-1:0]       exp;
    } vec_t;

    vec_t tbl[5];

    function automatic logic [FW-1:0] pk(int a, int b, int c, int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic check(string name, logic [FW-1:0] got, logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(logic [FW-1:0] v);
        tick();
        bus.vld_in = 1'b1;
        bus.din    = v;
        tick();
        bus.vld_in = 1'b0;
    endtask

    task automatic do_start(int num);
        bus.start     = 1'b1;
        bus.num_neigh = 4'(num);
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        tbl[0] = '{"mix3", 3, {pk(-1,-2,-3,-4), pk(10,20,30,40), pk(1,2,3,4)}, pk(10,20,30,40)};
`ifdef AGG_SATURATE_EN
        tbl[1] = '{"pos_ovf", 2, {FW'(0), pk(100,0,0,0), pk(100,0,0,0)}, pk(127,0,0,0)};
        tbl[2] = '{"neg_ovf", 2, {FW'(0), pk(-128,1,0,0), pk(-128,1,0,0)}, pk(-128,2,0,0)};
        tbl[4] = '{"extremes", 3, {pk(1,0,10,-10), pk(127,-128,-60,60), pk(127,-128,50,-50)},
                   pk(127,-128,0,0)};
`else
        tbl[1] = '{"pos_ovf", 2, {FW'(0), pk(100,0,0,0), pk(100,0,0,0)}, pk(-56,0,0,0)};
        tbl[2] = '{"neg_ovf", 2, {FW'(0), pk(-128,1,0,0), pk(-128,1,0,0)}, pk(0,2,0,0)};
        tbl[4] = '{"extremes", 3, {pk(1,0,10,-10), pk(127,-128,-60,60), pk(127,-128,50,-50)},
                   pk(-1,0,0,0)};
`endif
        tbl[3] = '{"single", 1, {FW'(0), FW'(0), pk(5,5,5,5)}, pk(5,5,5,5)};

        arst = 1'b1;
        bus.start = 1'b0; bus.num_neigh = '0; bus.vld_in = 1'b0; bus.din = '0; bus.rdy_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld_out", FW'(bus.vld_out), 0);
        check("rst_busy", FW'(bus.busy), 0);
        check("rst_ready_out", FW'(bus.ready_out), 0);
        check("rst_drop_err", FW'(bus.drop_err), 0);
        check("rst_dout", bus.dout, 0);
        arst = 1'b0;
        tick();

        // Table: start, vectors on non-consecutive cycles, result one cycle after the last vector.
        foreach (tbl[k]) begin
            do_start(tbl[k].n);
            @(negedge clk);
            check({tbl[k].name, "_ready_out"}, FW'(bus.ready_out), 1);
            for (int i = 0; i < tbl[k].n; i++) feed(tbl[k].v[i]);
            @(negedge clk);
            $display("vec %s dout=%h exp=%h vld_out=%0d", tbl[k].name, bus.dout, tbl[k].exp, bus.vld_out);
            check({tbl[k].name, "_vld_out"}, FW'(bus.vld_out), 1);
            check({tbl[k].name, "_dout"}, bus.dout, tbl[k].exp);
            tick();
            @(negedge clk);
            check({tbl[k].name, "_busy_after"}, FW'(bus.busy), 0);
            check({tbl[k].name, "_vld_after"}, FW'(bus.vld_out), 0);
            check({tbl[k].name, "_dout_after"}, bus.dout, 0);
            tick();
        end

        // num_neigh=0: immediate zero result held while downstream stalls.
        bus.rdy_in = 1'b0;
        do_start(0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("zero_vld_hold", FW'(bus.vld_out), 1);
            check("zero_dout_hold", bus.dout, 0);
            tick();
        end
        $display("seq zero_count done");
        bus.rdy_in = 1'b1;
        tick();
        @(negedge clk);
        check("zero_release", FW'(bus.busy), 0);
        tick();

        // Non-zero result stays stable under backpressure; vld_in during OUTPUT is dropped.
        bus.rdy_in = 1'b0;
        do_start(1);
        feed(pk(7,-7,3,0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_vld", FW'(bus.vld_out), 1);
            check("stall_dout", bus.dout, pk(7,-7,3,0));
            tick();
        end
        check("stall_no_err", FW'(bus.drop_err), 0);
        feed(pk(9,9,9,9));
        @(negedge clk);
        check("output_drop_err", FW'(bus.drop_err), 1);
        check("output_drop_dout", bus.dout, pk(7,-7,3,0));
        $display("seq stall done dout=%h", bus.dout);
        bus.rdy_in = 1'b1;
        tick();
        tick();

        // Drops in IDLE and in the start cycle; next start clears the flag.
        do_start(2);
        feed(pk(1,1,1,1));
        feed(pk(1,1,1,1));
        tick();
        feed(pk(60,60,60,60));
        @(negedge clk);
        check("idle_drop_err", FW'(bus.drop_err), 1);
        bus.start = 1'b1; bus.num_neigh = 4'd1; bus.vld_in = 1'b1; bus.din = pk(50,50,50,50);
        tick();
        bus.start = 1'b0; bus.vld_in = 1'b0;
        @(negedge clk);
        check("start_cycle_drop_err", FW'(bus.drop_err), 1);
        feed(pk(1,2,3,4));
        @(negedge clk);
        check("start_cycle_no_sum", bus.dout, pk(1,2,3,4));
        tick();
        do_start(1);
        @(negedge clk);
        check("drop_err_cleared", FW'(bus.drop_err), 0);
        feed(pk(2,2,2,2));
        tick();
        $display("seq drop done");

        // Asynchronous reset mid-aggregation discards the partial sum.
        do_start(3);
        feed(pk(9,9,9,9));
        @(negedge clk);
        arst = 1'b1;
        #2;
        check("arst_busy", FW'(bus.busy), 0);
        check("arst_ready_out", FW'(bus.ready_out), 0);
        arst = 1'b0;
        tick();
        do_start(1);
        feed(pk(5,5,5,5));
        @(negedge clk);
        check("post_arst_vld", FW'(bus.vld_out), 1);
        check("post_arst_dout", bus.dout, pk(5,5,5,5));
        $display("seq arst dout=%h", bus.dout);
        tick();

        // A second start while busy must not reload the count.
        do_start(3);
        feed(pk(1,1,1,1));
        do_start(1);
        feed(pk(2,2,2,2));
        @(negedge clk);
        check("restart_ignored_vld", FW'(bus.vld_out), 0);
        check("restart_ignored_busy", FW'(bus.busy), 1);
        feed(pk(3,-3,3,-3));
        @(negedge clk);
        check("restart_final_vld", FW'(bus.vld_out), 1);
        check("restart_final_dout", bus.dout, pk(6,0,6,0));
        $display("seq restart dout=%h", bus.dout);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vector_aggregator.md
Name: vector_aggregator

Overview:
- Sits directly downstream of the vectorization unit; consumes its assembled feature vectors (FEATURES lanes of DATA_WIDTH).
- Sums a programmed number of neighbour vectors lane-wise into wide accumulators, then presents one aggregated vector to the next stage with a valid/ready handshake.
- Forms the core sum-aggregation step of the aggregation engine. One aggregation runs at a time.

Parameters:
FEATURES, 4, number of lanes per vector
DATA_WIDTH, 8, signed two's-complement width of each lane
CNT_W, 4, width of neighbour count; max count 2**CNT_W-1
ACC_WIDTH, DATA_WIDTH+CNT_W, per-lane accumulator width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
arst  input  1  asynchronous reset, active-high
start  input  1  one-cycle pulse: begin aggregation
num_neigh  input  CNT_W  number of vectors to sum, sampled on accepted start
vld_in  input  1  input vector valid (one-cycle pulse from vectorization unit)
din  input  FEATURES*DATA_WIDTH  input vector; lane i = din[i*DATA_WIDTH +: DATA_WIDTH]
ready_out  output  1  high while in ACCUM (informational; upstream has no backpressure)
vld_out  output  1  aggregated vector valid
dout  output  FEATURES*DATA_WIDTH  aggregated vector, same lane packing
rdy_in  input  1  downstream ready
busy  output  1  high in ACCUM or OUTPUT
drop_err  output  1  sticky: vector arrived while not in ACCUM

Behaviour:
- Reset (arst high, any time, including mid-aggregation): state IDLE; accumulators, remaining count, dout, vld_out, ready_out, busy, drop_err all 0. Partial sums are discarded.
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE:
  - start=1 and num_neigh>0: clear accumulators, load remaining=num_neigh, clear drop_err, go to ACCUM.
  - start=1 and num_neigh=0: clear accumulators and drop_err, go directly to OUTPUT; dout=0.
  - vld_in in IDLE: vector dropped, drop_err set.
- ACCUM:
  - ready_out=1.
  - On each vld_in: acc[i] += sign-extend(lane i); remaining decrements.
  - When remaining reaches 0 on an accept, go to OUTPUT.
  - vld_in in the same cycle as the accepted start is not accumulated; it is dropped and drop_err is set.
  - start while busy: ignored; num_neigh not resampled.
- Arithmetic: ACC_WIDTH covers the max count, so accumulators never overflow.
- Latency: last vector accepted in cycle t gives vld_out=1 and valid dout in cycle t+1.
- OUTPUT:
  - vld_out=1 and dout held stable until vld_out&&rdy_in.
  - Handshake cycle: return to IDLE next cycle, vld_out=0.
  - rdy_in held high gives a one-cycle vld_out.
  - vld_in during OUTPUT: dropped, drop_err set.
- dout narrowing without the optional feature: lane i = acc[i][DATA_WIDTH-1:0] (wraps).
- dout is registered; 0 outside OUTPUT.
- busy = (state != IDLE).

Optional Feature:
- Macro: AGG_SATURATE_EN.
- Defined: each lane saturates to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1] when acc[i] is out of range. For defaults: acc=200 gives 127; acc=-300 gives -128.
- Undefined: truncation, so acc=200 gives -56 (0xC8).
- Ports and timing are identical in both builds.

Test Plan:
1. start, num_neigh=3; vectors {1,2,3,4}, {10,20,30,40}, {-1,-2,-3,-4} on non-consecutive cycles, rdy_in=1 -> vld_out one cycle after 3rd vector, dout={10,20,30,40}, busy low the following cycle.
2. start, num_neigh=0 -> vld_out the cycle after start, dout=0; rdy_in held low 5 cycles -> vld_out and dout stable all 5 cycles.
3. num_neigh=2; lane0 inputs 100, 100 -> without AGG_SATURATE_EN dout lane0=-56; with it, lane0=127. Lane0 inputs -128, -128 with AGG_SATURATE_EN -> -128.
4. vld_in pulsed in IDLE and in the start cycle -> drop_err=1, no contribution to sum. Next start -> drop_err cleared.
5. arst pulsed after 1 of 3 vectors; new start, num_neigh=1, vector {5,5,5,5} -> dout={5,5,5,5}, with no residue from before the reset.
6. second start during ACCUM with num_neigh=1 -> ignored; aggregation still waits for the original count.
